// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx
// Purpose  : Wishbone slave UART transmitter. The CPU pushes bytes through a
//            four-word register window into a TX FIFO. A baud-rate FSM
//            serialises them as 8N1 frames on uart_tx_o. An optional even
//            parity bit is available when UART_TX_PARITY_EN is defined.
//            A level interrupt reports that transmission has drained.
// Ports    : clk, rst_n            - single clock, async active-low reset
//            wb_cyc_i/stb_i/we_i   - Wishbone request qualifiers
//            wb_adr_i              - byte address, [3:2] selects register
//            wb_dat_i/sel_i        - write data and byte selects
//            wb_dat_o              - read data, valid in the ack cycle
//            wb_ack_o/err_o        - registered response, one cycle later
//            wb_stall_o            - tied low
//            uart_tx_o             - serial line, idle high, registered
//            irq_o                 - TX-drained interrupt, registered
// Registers: 0 DATA (W push / R 0), 1 STATUS, 2 DIV, 3 CTRL
// Options  : `define UART_TX_PARITY_EN enables CTRL.par_en and PARITY state
// Revision : 1.0 - initial release
// ============================================================================

`ifndef WB_COM_AWIDTH
`define WB_COM_AWIDTH 32
`endif
`ifndef WB_COM_DWIDTH
`define WB_COM_DWIDTH 32
`endif

module wb_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wb_cyc_i,
    input  logic                            wb_stb_i,
    input  logic                            wb_we_i,
    input  logic [`WB_COM_AWIDTH-1:0]       wb_adr_i,
    input  logic [`WB_COM_DWIDTH-1:0]       wb_dat_i,
    input  logic [`WB_COM_DWIDTH/8-1:0]     wb_sel_i,
    output logic [`WB_COM_DWIDTH-1:0]       wb_dat_o,
    output logic                            wb_ack_o,
    output logic                            wb_err_o,
    output logic                            wb_stall_o,
    output logic                            uart_tx_o,
    output logic                            irq_o
);

    localparam int unsigned c_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned c_PW = c_AW + 1;
    localparam int unsigned c_DW = `WB_COM_DWIDTH;

    localparam logic [1:0] c_ADR_DATA   = 2'd0;
    localparam logic [1:0] c_ADR_STATUS = 2'd1;
    localparam logic [1:0] c_ADR_DIV    = 2'd2;
    localparam logic [1:0] c_ADR_CTRL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_bit_q, par_bit_d;
    logic                par_frame_q, par_frame_d;
    logic                tx_q, tx_d;

    logic [15:0]         div_q;
    logic                ctrl_en_q;
    logic                ctrl_irq_q;
    logic                w_ctrl_par;

    logic [7:0]          fifo_mem_q [FIFO_DEPTH];
    logic [c_PW-1:0]     wr_ptr_q;
    logic [c_PW-1:0]     rd_ptr_q;
    logic [c_PW-1:0]     w_level;
    logic                w_full;
    logic                w_empty;
    logic [7:0]          w_head;

    logic                w_req;
    logic                w_wr;
    logic                w_rd;
    logic [1:0]          w_adr;
    logic                w_data_wr;
    logic                w_push;
    logic                w_ovf;
    logic                w_pop;
    logic                w_bit_end;
    logic                w_can_start;
    logic [c_DW-1:0]     w_rdata;

    logic                ack_q;
    logic                err_q;
    logic [c_DW-1:0]     dat_q;
    logic                irq_q;

    // Only [3:2] of the address, the low data half-word and sel[1:0] matter.
    logic                w_unused;
    assign w_unused = &{1'b0, wb_adr_i[`WB_COM_AWIDTH-1:4], wb_adr_i[1:0],
                        wb_dat_i[c_DW-1:16], wb_sel_i[c_DW/8-1:2]};

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_wr      = w_req & wb_we_i;
    assign w_rd      = w_req & ~wb_we_i;
    assign w_adr     = wb_adr_i[3:2];

    // A DATA write without sel[0] carries no byte: it is acked but ignored.
    assign w_data_wr = w_wr & (w_adr == c_ADR_DATA) & wb_sel_i[0];
    // Fullness is taken before any same-cycle pop, so a push into a full
    // FIFO is rejected even if the FSM frees a slot in that cycle.
    assign w_ovf     = w_data_wr & w_full;
    assign w_push    = w_data_wr & ~w_full;

    // ------------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit so full and empty differ
    // ------------------------------------------------------------------------
    assign w_level = wr_ptr_q - rd_ptr_q;
    assign w_full  = (w_level == c_PW'(FIFO_DEPTH));
    assign w_empty = (w_level == '0);
    assign w_head  = fifo_mem_q[rd_ptr_q[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q[c_AW-1:0]] <= wb_dat_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DIV_RESET;
            ctrl_en_q  <= 1'b0;
            ctrl_irq_q <= 1'b0;
        end else begin
            if (w_wr && (w_adr == c_ADR_DIV)) begin
                if (wb_sel_i[0]) begin
                    div_q[7:0] <= wb_dat_i[7:0];
                end
                if (wb_sel_i[1]) begin
                    div_q[15:8] <= wb_dat_i[15:8];
                end
            end
            if (w_wr && (w_adr == c_ADR_CTRL) && wb_sel_i[0]) begin
                ctrl_en_q  <= wb_dat_i[0];
                ctrl_irq_q <= wb_dat_i[1];
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic ctrl_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_par_q <= 1'b0;
        end else if (w_wr && (w_adr == c_ADR_CTRL) && wb_sel_i[0]) begin
            ctrl_par_q <= wb_dat_i[2];
        end
    end

    assign w_ctrl_par = ctrl_par_q;
`else
    assign w_ctrl_par = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    assign w_bit_end   = (cnt_q == 16'd0);
    assign w_can_start = ctrl_en_q & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            par_bit_q   <= 1'b0;
            par_frame_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            par_frame_q <= par_frame_d;
            tx_q        <= tx_d;
        end
    end

    // tx_d is the level of the *next* cycle, so each bit is launched from the
    // cycle that ends the previous one and the line never glitches.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_frame_d = par_frame_q;
        tx_d        = tx_q;
        w_pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                w_pop = w_can_start;
            end

            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = div_q;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d   = cnt_q - 16'd1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        if (par_frame_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = div_q;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 16'd1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    // Chaining straight into START keeps back-to-back frames
                    // free of idle cycles.
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    w_pop   = w_can_start;
                end else begin
                    cnt_d   = cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame launch shared by IDLE and STOP: load the head byte, latch
        // its parity and the parity enable for the whole frame.
        if (w_pop) begin
            state_d     = S_START;
            cnt_d       = div_q;
            bit_d       = 3'd0;
            shift_d     = w_head;
            par_bit_d   = ^w_head;
            par_frame_d = w_ctrl_par;
            tx_d        = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read mux and registered response
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            c_ADR_STATUS: begin
                w_rdata[0]    = w_full;
                w_rdata[1]    = w_empty;
                w_rdata[2]    = (state_q != S_IDLE);
                w_rdata[15:8] = 8'(w_level);
            end
            c_ADR_DIV: begin
                w_rdata[15:0] = div_q;
            end
            c_ADR_CTRL: begin
                w_rdata[2:0]  = {w_ctrl_par, ctrl_irq_q, ctrl_en_q};
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= w_req & ~w_ovf;
            err_q <= w_ovf;
            dat_q <= w_rd ? w_rdata : '0;
            irq_q <= ctrl_irq_q & w_empty & (state_q == S_IDLE);
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign uart_tx_o  = tx_q;
    assign irq_o      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_tx
// Purpose  : Self-checking bench for wb_uart_tx: a register-access vector
//            table plus directed frame sequences (timing, overflow,
//            back-to-back frames, irq, DIV change, tx_en clear, parity,
//            reset mid-frame). Define UART_TX_PARITY_EN for the parity build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;
    logic        uart_tx_o;
    logic        irq_o;

    int n_cmp;
    int n_bad;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] CTRL_ALL = 32'h7;
`else
    localparam logic [31:0] CTRL_ALL = 32'h3;
`endif

    wb_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd433)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .uart_tx_o  (uart_tx_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_drive(input logic we, input logic [1:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = 32'h4000_0000 | {28'd0, adr, 2'b00};
        wb_dat_i = dat;
        wb_sel_i = sel;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
    endtask

    // One request cycle; response sampled 1 time unit after the edge.
    task automatic xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic ack, output logic err,
                        output logic [31:0] rd);
        @(negedge clk);
        bus_drive(we, adr, dat, sel);
        @(posedge clk);
        #1;
        bus_idle();
        ack = wb_ack_o;
        err = wb_err_o;
        rd  = wb_dat_o;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        logic a, e;
        logic [31:0] r;
        xfer(1'b1, adr, dat, 4'hF, a, e, r);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] adr, input logic [31:0] exp);
        logic a, e;
        logic [31:0] r;
        xfer(1'b0, adr, 32'h0, 4'hF, a, e, r);
        chk({nm, " ack"}, {31'd0, a}, 32'd1);
        chk(nm, r, exp);
    endtask

    // Watches one frame on the line, one sample per cycle at the falling edge.
    // An optional bus access is issued during the first start-bit cycle.
    task automatic check_frame(input logic [7:0] b, input int div0, input int div1,
                               input logic par_on, input logic immediate,
                               input logic hk_en, input logic hk_we,
                               input logic [1:0] hk_adr, input logic [31:0] hk_dat,
                               output logic [31:0] hk_rd);
        logic exp_bits [11];
        logic seen;
        logic ok;
        int   nb;
        int   len;
        nb = par_on ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        exp_bits[9]  = par_on ? (^b) : 1'b1;
        exp_bits[10] = 1'b1;
        hk_rd = 32'h0;
        seen  = 1'b0;
        if (immediate) begin
            @(negedge clk);
            seen = (uart_tx_o === 1'b0);
        end else begin
            for (int t = 0; t < 200 && !seen; t++) begin
                @(negedge clk);
                if (uart_tx_o === 1'b0) seen = 1'b1;
            end
        end
        chk($sformatf("frame %02h start seen", b), {31'd0, seen}, 32'd1);
        if (!seen) return;
        for (int i = 0; i < nb; i++) begin
            len = ((i == 0) ? div0 : div1) + 1;
            ok  = 1'b1;
            for (int k = 0; k < len; k++) begin
                if (i != 0 || k != 0) @(negedge clk);
                if (hk_en && i == 0 && k == 0) bus_drive(hk_we, hk_adr, hk_dat, 4'hF);
                if (hk_en && i == 0 && k == 1) begin
                    hk_rd = wb_dat_o;
                    bus_idle();
                end
                if (uart_tx_o !== exp_bits[i]) ok = 1'b0;
            end
            chk($sformatf("frame %02h bit%0d held at %0b for %0d clk", b, i, exp_bits[i], len),
                {31'd0, ok}, 32'd1);
        end
    endtask

    initial begin
        logic        a, e;
        logic [31:0] r;
        logic [31:0] hk;
        logic        ok;
        logic        seen;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        bus_idle();

        //             we    adr   dat           sel   ack   err   chkd  exp
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0002};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_01B1};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_1234, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_1234};
        vecs[6]  = '{1'b1, 2'd2, 32'h0000_56AB, 4'h1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_12AB};
        vecs[8]  = '{1'b1, 2'd2, 32'h0000_CD00, 4'h2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_CDAB};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hE, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'h1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, CTRL_ALL};
        vecs[14] = '{1'b1, 2'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 2'd0, 32'h0000_005A, 4'hE, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0002};
        vecs[17] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx line", {31'd0, uart_tx_o}, 32'd1);
        chk("reset irq", {31'd0, irq_o}, 32'd0);
        chk("reset ack/err", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- register table ----------------
        for (int i = 0; i < 18; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a, e, r);
            chk($sformatf("vec%0d ack/err", i), {30'd0, a, e},
                {30'd0, vecs[i].exp_ack, vecs[i].exp_err});
            if (vecs[i].chk_dat) chk($sformatf("vec%0d rdata", i), r, vecs[i].exp_dat);
        end
        chk("stall", {31'd0, wb_stall_o}, 32'd0);

        // ---------------- basic 8N1 frame, DIV=3 ----------------
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1);
        wr(2'd0, 32'hA5);
        check_frame(8'hA5, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0, hk);
        chk("busy STATUS mid-frame", hk, 32'h0000_0006);
        repeat (2) @(negedge clk);
        chk("line idle after frame", {31'd0, uart_tx_o}, 32'd1);

        // ---------------- irq ----------------
        wr(2'd2, 32'd0);
        wr(2'd3, 32'h3);
        repeat (2) @(negedge clk);
        chk("irq drained idle", {31'd0, irq_o}, 32'd1);
        wr(2'd0, 32'h01);
        check_frame(8'h01, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, hk);
        chk("irq low during stop", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        chk("irq low first idle cycle", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        chk("irq high after stop", {31'd0, irq_o}, 32'd1);

        // ---------------- overflow + back-to-back ----------------
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd1);
        for (int i = 0; i < 9; i++) begin
            xfer(1'b1, 2'd0, 32'h30 + i, 4'hF, a, e, r);
            chk($sformatf("fill write %0d ack/err", i + 1), {30'd0, a, e},
                (i < 8) ? 32'h2 : 32'h1);
        end
        rd_chk("STATUS full", 2'd1, 32'h0000_0801);
        wr(2'd3, 32'h1);
        for (int i = 0; i < 8; i++) begin
            check_frame(8'(8'h30 + i), 1, 1, 1'b0, (i != 0), 1'b0, 1'b0, 2'd0, 32'h0, hk);
        end
        @(negedge clk);
        chk("idle after burst", {31'd0, uart_tx_o}, 32'd1);
        rd_chk("STATUS after burst", 2'd1, 32'h0000_0002);

        // ---------------- DIV change mid-frame ----------------
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h96);
        check_frame(8'h96, 3, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'd1, hk);
        rd_chk("DIV after change", 2'd2, 32'h0000_0001);

`ifdef UART_TX_PARITY_EN
        // ---------------- parity ----------------
        wr(2'd2, 32'd0);
        wr(2'd3, 32'h5);
        rd_chk("CTRL par", 2'd3, 32'h0000_0005);
        wr(2'd0, 32'h07);
        check_frame(8'h07, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, hk);
        wr(2'd0, 32'h03);
        check_frame(8'h03, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, hk);
        wr(2'd2, 32'd1);
`endif

        // ---------------- tx_en cleared mid-frame ----------------
        wr(2'd3, 32'h0);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'h77);
        wr(2'd3, 32'h1);
        check_frame(8'h3C, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h0, hk);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) ok = 1'b0;
        end
        chk("line held idle after tx_en clear", {31'd0, ok}, 32'd1);
        rd_chk("STATUS one left", 2'd1, 32'h0000_0100);

        // ---------------- reset mid-frame ----------------
        wr(2'd0, 32'h11);
        wr(2'd3, 32'h1);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (uart_tx_o === 1'b0) seen = 1'b1;
        end
        chk("reset test frame start", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("line high on async reset", {31'd0, uart_tx_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("STATUS after reset", 2'd1, 32'h0000_0002);
        rd_chk("DIV after reset", 2'd2, 32'h0000_01B1);
        rd_chk("CTRL after reset", 2'd3, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone slave UART transmitter.
- Attaches as an additional slave on the peripheral crossbar, alongside the boot ROM and GPIO.
- CPU pushes bytes through a register window into a TX FIFO. A baud-rate FSM serialises them on uart_tx_o as 8N1 frames, with an optional parity bit.
- Provides a level interrupt when transmission has drained.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 16'd433, reset value of DIV; gives 115200 baud at 50 MHz.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  `WB_COM_AWIDTH  byte address; only [3:2] decoded.
- wb_dat_i  in  `WB_COM_DWIDTH  write data.
- wb_sel_i  in  `WB_COM_DWIDTH/8  byte selects.
- wb_dat_o  out  `WB_COM_DWIDTH  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  transfer error.
- wb_stall_o  out  1  constant 0.
- uart_tx_o  out  1  serial output; idle high.
- irq_o  out  1  TX-drained interrupt.

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, uart_tx_o=1, irq_o=0, FIFO empty, FSM IDLE, DIV=DIV_RESET, CTRL=0.
- Reset mid-frame: line returns high immediately; FIFO contents are lost.
- Register map (wb_adr_i[3:2]):
  - 0 DATA: W pushes wb_dat_i[7:0]; R returns 0.
  - 1 STATUS: RO. bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bits[15:8] FIFO level.
  - 2 DIV: RW [15:0]; upper bits read 0.
  - 3 CTRL: RW. bit0 tx_en, bit1 irq_en, bit2 par_en (reserved without the option); other bits read 0.
- Request and acknowledge:
  - A request is wb_cyc_i & wb_stb_i. Stall is never asserted, so one request is accepted per cycle and back-to-back requests are legal.
  - ack or err is registered and asserted exactly one cycle after each request, never both.
  - wb_dat_o is valid in the ack cycle.
- Byte selects:
  - DIV writes honour sel[1:0].
  - CTRL writes honour sel[0].
  - A DATA write with sel[0]=0 is acked with no push.
- FIFO overflow: a DATA write while full returns err, and the byte is dropped. A push and a pop in the same cycle while full is still an error (full is sampled before the pop).
- FIFO: circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH). Pointers wrap naturally. Simultaneous push and pop leaves the level unchanged.
- Baud timer: 16-bit down-counter, reloaded with DIV at each bit start. A bit lasts DIV+1 clk cycles; DIV=0 gives 1 cycle per bit.
- DIV writes mid-frame take effect at the next bit boundary.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
  - IDLE -> START when tx_en=1 and FIFO not empty. Pop the FIFO head into the shift register in that cycle; the line goes low the next cycle.
  - START -> DATA after one bit time.
  - DATA shifts LSB first; 3-bit counter; -> STOP after bit 7.
  - STOP drives 1 for one bit time, then goes to IDLE, or directly to START if tx_en=1 and FIFO not empty. Back-to-back frames have no extra idle cycles.
  - Clearing tx_en mid-frame completes the current frame, then holds IDLE.
- uart_tx_o is driven from a register (glitch-free).
- irq_o is registered: irq_en & empty & FSM==IDLE, delayed one cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - CTRL.bit2 par_en is writable.
  - When par_en=1, a PARITY state is inserted between DATA and STOP. It drives the even parity (XOR of the 8 data bits) for one bit time, giving an 11-bit frame.
  - par_en is sampled at the pop from the FIFO and held for that frame.
- Undefined: CTRL.bit2 reads 0, writes are ignored, and frames are always 10 bits.

Test Plan:
- Reset, then read all four registers -> DIV=433, CTRL=0, STATUS=0x0000_0002; uart_tx_o=1, irq_o=0.
- DIV=3, CTRL=1, write DATA=0xA5 -> line low for 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each), then high for 4 clk. busy=1 throughout; 40 clk total.
- tx_en=0, nine consecutive DATA writes with DEPTH=8 -> writes 1-8 acked, write 9 err; STATUS shows full=1, level=8. Set tx_en=1 -> exactly 8 frames back-to-back, no gap cycles.
- CTRL=3 (irq_en), DIV=0, write 0x01 -> irq_o drops once the frame starts and returns high one cycle after STOP ends, with the FIFO empty.
- Write DIV=1 during a frame started with DIV=3 -> the current bit finishes at 4 clk, later bits are 2 clk. Clearing tx_en mid-frame completes the frame.
- With UART_TX_PARITY_EN, CTRL=5, DIV=0, DATA=0x07 -> 11-bit frame with parity bit 1; with DATA=0x03, parity bit 0.
